jt900h_busarb: RTL and testbench

Two-requester arbiter and access sequencer for the JT900H 16-bit external memory bus. It sits between the CPU memory controller and the micro-DMA engine, and grants the single RAM port to one of them per access. For each access it drives address, write data and byte write enables, inserts wait states, and returns read data with a one-cycle acknowledge.

---
 rtl/jt900h_busarb_if.sv | 49 ++++
 rtl/jt900h_busarb.sv | 172 +++++++++++++++++
 tb/tb_jt900h_busarb.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt900h_busarb_if.sv
// jt900h_busarb_if: request/acknowledge and RAM-side signals of the JT900H
// external bus arbiter, bundled so the arbiter and its environment share one
// connection point. The arbiter uses the master modport; the requesters plus
// RAM model use the slave modport.
interface jt900h_busarb_if;

  // CPU memory controller side
  logic        cpu_req;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [1:0]  cpu_we;
  logic        cpu_ack;

  // micro-DMA engine side
  logic        dma_req;
  logic [23:0] dma_addr;
  logic [15:0] dma_din;
  logic [1:0]  dma_we;
  logic        dma_ack;

  // shared read data and grant indicator
  logic [15:0] rdata;
  logic        dma_gnt;

  // RAM port
  logic [23:0] bus_addr;
  logic [15:0] bus_din;
  logic [1:0]  bus_we;
  logic        bus_cs;
  logic [15:0] bus_dout;
  logic        bus_wait;

  modport master (
    input  cpu_req, cpu_addr, cpu_din, cpu_we,
    input  dma_req, dma_addr, dma_din, dma_we,
    input  bus_dout, bus_wait,
    output cpu_ack, dma_ack, rdata, dma_gnt,
    output bus_addr, bus_din, bus_we, bus_cs
  );

  modport slave (
    output cpu_req, cpu_addr, cpu_din, cpu_we,
    output dma_req, dma_addr, dma_din, dma_we,
    output bus_dout, bus_wait,
    input  cpu_ack, dma_ack, rdata, dma_gnt,
    input  bus_addr, bus_din, bus_we, bus_cs
  );

endinterface

// File: rtl/jt900h_busarb.sv
// jt900h_busarb: grants the single 16-bit RAM port to either the CPU memory
// controller or the micro-DMA engine, sequences one access at a time with a
// fixed number of wait states and returns read data with a one-cycle ack.
// DMA wins contention by default; a 4-bit fairness counter forces a CPU grant
// after MAXDMA consecutive DMA grants while the CPU is kept waiting.
// Optional feature macro: JT900H_BUSARB_WAIT_EN. When defined, bus_wait=1 in
// the final access cycle stretches the access; when undefined bus_wait is
// ignored and every access lasts 2+WAITS cycles up to its ack.
module jt900h_busarb #(
  parameter int WAITS  = 0,
  parameter int MAXDMA = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  jt900h_busarb_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  localparam logic [2:0] WaitLoad = 3'(WAITS);
  localparam logic [3:0] FairMax  = 4'(MAXDMA);

  state_t      state_q,    state_d;
  logic [2:0]  wcnt_q,     wcnt_d;
  logic [3:0]  fair_q,     fair_d;
  logic [23:0] bus_addr_q, bus_addr_d;
  logic [15:0] bus_din_q,  bus_din_d;
  logic [1:0]  bus_we_q,   bus_we_d;
  logic        bus_cs_q,   bus_cs_d;
  logic [15:0] rdata_q,    rdata_d;
  logic        cpu_ack_q,  cpu_ack_d;
  logic        dma_ack_q,  dma_ack_d;
  logic        dma_gnt_q,  dma_gnt_d;

  logic cpu_elig;
  logic dma_elig;
  logic cpu_win;
  logic ext_wait;

`ifdef JT900H_BUSARB_WAIT_EN
  assign ext_wait = bus.bus_wait;
`else
  logic unused_bus_wait;
  assign ext_wait        = 1'b0;
  assign unused_bus_wait = bus.bus_wait;
`endif

  // A requester competes only while it is not being acknowledged, and the CPU
  // beats DMA when DMA is absent or DMA has used up its allowance of grants.
  always_comb begin
    cpu_elig = bus.cpu_req & ~cpu_ack_q;
    dma_elig = bus.dma_req & ~dma_ack_q;
    cpu_win  = cpu_elig & (~dma_elig | ((fair_q == FairMax) & bus.cpu_req));
  end

  // Next-state and next-output logic; everything holds when cen=0.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    fair_d     = fair_q;
    bus_addr_d = bus_addr_q;
    bus_din_d  = bus_din_q;
    bus_we_d   = bus_we_q;
    bus_cs_d   = bus_cs_q;
    rdata_d    = rdata_q;
    cpu_ack_d  = cpu_ack_q;
    dma_ack_d  = dma_ack_q;
    dma_gnt_d  = dma_gnt_q;

    if (cen) begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_elig || dma_elig) begin
            state_d  = ST_ACCESS;
            bus_cs_d = 1'b1;
            wcnt_d   = WaitLoad;
            if (cpu_win) begin
              bus_addr_d = bus.cpu_addr;
              bus_din_d  = bus.cpu_din;
              bus_we_d   = bus.cpu_we;
              dma_gnt_d  = 1'b0;
              fair_d     = 4'd0;
            end else begin
              bus_addr_d = bus.dma_addr;
              bus_din_d  = bus.dma_din;
              bus_we_d   = bus.dma_we;
              dma_gnt_d  = 1'b1;
              if (!bus.cpu_req) begin
                fair_d = 4'd0;
              end else if (fair_q != FairMax) begin
                fair_d = fair_q + 4'd1;
              end
            end
          end else if (!bus.cpu_req) begin
            fair_d = 4'd0;
          end
        end

        ST_ACCESS: begin
          if (wcnt_q != 3'd0) begin
            wcnt_d = wcnt_q - 3'd1;
          end else if (!ext_wait) begin
            rdata_d   = bus.bus_dout;
            bus_cs_d  = 1'b0;
            bus_we_d  = 2'b00;
            state_d   = ST_DONE;
            cpu_ack_d = ~dma_gnt_q;
            dma_ack_d = dma_gnt_q;
          end
        end

        ST_DONE: begin
          cpu_ack_d = 1'b0;
          dma_ack_d = 1'b0;
          state_d   = ST_IDLE;
        end

        default: begin
          state_d   = ST_IDLE;
          bus_cs_d  = 1'b0;
          bus_we_d  = 2'b00;
          cpu_ack_d = 1'b0;
          dma_ack_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 3'd0;
      fair_q     <= 4'd0;
      bus_addr_q <= 24'd0;
      bus_din_q  <= 16'd0;
      bus_we_q   <= 2'b00;
      bus_cs_q   <= 1'b0;
      rdata_q    <= 16'd0;
      cpu_ack_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
      dma_gnt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      fair_q     <= fair_d;
      bus_addr_q <= bus_addr_d;
      bus_din_q  <= bus_din_d;
      bus_we_q   <= bus_we_d;
      bus_cs_q   <= bus_cs_d;
      rdata_q    <= rdata_d;
      cpu_ack_q  <= cpu_ack_d;
      dma_ack_q  <= dma_ack_d;
      dma_gnt_q  <= dma_gnt_d;
    end
  end

  assign bus.bus_addr = bus_addr_q;
  assign bus.bus_din  = bus_din_q;
  assign bus.bus_we   = bus_we_q;
  assign bus.bus_cs   = bus_cs_q;
  assign bus.rdata    = rdata_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.dma_ack  = dma_ack_q;
  assign bus.dma_gnt  = dma_gnt_q;

endmodule

// File: tb/tb_jt900h_busarb.sv
// tb_jt900h_busarb: directed scenarios plus randomized CPU/DMA traffic for
// jt900h_busarb, checked every cycle against a transaction-level model of the
// arbiter kept in the bench.
module tb_jt900h_busarb;

  localparam int TbWaits  = 2;
  localparam int TbMaxDma = 4;
`ifdef JT900H_BUSARB_WAIT_EN
  localparam bit WaitEn = 1'b1;
`else
  localparam bit WaitEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  jt900h_busarb_if bif ();

  jt900h_busarb #(
    .WAITS (TbWaits),
    .MAXDMA(TbMaxDma)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cen(cen),
    .bus(bif)
  );

  always #5 clk = ~clk;

  // Expected outputs, derived from transactions: a grant starts an access,
  // the access ends TbWaits+1 enabled edges later (plus external waits),
  // then one enabled edge of ack before the port is free again.
  bit          m_busy   = 1'b0;
  int          m_age    = 0;
  int          m_streak = 0;
  bit          e_cs     = 1'b0;
  logic [1:0]  e_we     = 2'b00;
  logic [1:0]  m_we     = 2'b00;
  logic [23:0] e_addr   = 24'd0;
  logic [15:0] e_din    = 16'd0;
  logic [15:0] e_rdata  = 16'd0;
  bit          e_cack   = 1'b0;
  bit          e_dack   = 1'b0;
  bit          e_gnt    = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit ce, de, to_cpu;
    if (rst) begin
      m_busy = 0; m_age = 0; m_streak = 0;
      e_cs = 0; e_we = 0; m_we = 0; e_addr = 0; e_din = 0; e_rdata = 0;
      e_cack = 0; e_dack = 0; e_gnt = 0;
    end else if (cen) begin
      if (!m_busy) begin
        ce = bif.cpu_req && !e_cack;
        de = bif.dma_req && !e_dack;
        if (ce || de) begin
          to_cpu = ce && (!de || m_streak == TbMaxDma);
          if (to_cpu) begin
            e_addr = bif.cpu_addr; e_din = bif.cpu_din; m_we = bif.cpu_we;
            m_streak = 0;
          end else begin
            e_addr = bif.dma_addr; e_din = bif.dma_din; m_we = bif.dma_we;
            if (!bif.cpu_req) m_streak = 0;
            else if (m_streak < TbMaxDma) m_streak = m_streak + 1;
          end
          e_gnt = !to_cpu;
          e_we = m_we; e_cs = 1; m_busy = 1; m_age = 0;
        end else if (!bif.cpu_req) begin
          m_streak = 0;
        end
      end else if (e_cack || e_dack) begin
        e_cack = 0; e_dack = 0; m_busy = 0;
      end else begin
        m_age = m_age + 1;
        if (m_age > TbWaits && !(WaitEn && bif.bus_wait)) begin
          e_rdata = bif.bus_dout;
          e_cs = 0; e_we = 0;
          e_cack = !e_gnt; e_dack = e_gnt;
        end
      end
    end
  end

  // Every cycle, away from the clock edge, the DUT must agree with the model.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      checks++;
      if (bif.bus_cs !== e_cs || bif.bus_we !== e_we || bif.bus_addr !== e_addr ||
          bif.bus_din !== e_din || bif.rdata !== e_rdata || bif.cpu_ack !== e_cack ||
          bif.dma_ack !== e_dack || bif.dma_gnt !== e_gnt) begin
        errors++;
        $display("[TB] FAIL outputs @%0t: got cs=%b we=%b addr=%h din=%h rdata=%h cack=%b dack=%b gnt=%b, expected cs=%b we=%b addr=%h din=%h rdata=%h cack=%b dack=%b gnt=%b",
                 $time, bif.bus_cs, bif.bus_we, bif.bus_addr, bif.bus_din, bif.rdata,
                 bif.cpu_ack, bif.dma_ack, bif.dma_gnt,
                 e_cs, e_we, e_addr, e_din, e_rdata, e_cack, e_dack, e_gnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic newCpuReq();
    bif.cpu_req  = 1'b1;
    bif.cpu_addr = 24'($urandom);
    bif.cpu_din  = 16'($urandom);
    bif.cpu_we   = 2'($urandom_range(0, 3));
  endtask

  task automatic newDmaReq();
    bif.dma_req  = 1'b1;
    bif.dma_addr = 24'($urandom);
    bif.dma_din  = 16'($urandom);
    bif.dma_we   = 2'($urandom_range(0, 3));
  endtask

  // Random requesters obeying the protocol: hold a request until its ack,
  // then either drop it or present a new one straight away.
  task automatic applyStimulus();
    cen          = ($urandom_range(0, 3) != 0);
    bif.bus_dout = 16'($urandom);
    bif.bus_wait = ($urandom_range(0, 3) == 0);
    if (bif.cpu_ack) begin
      if (bif.cpu_req && $urandom_range(0, 1) == 1) newCpuReq();
      else bif.cpu_req = 1'b0;
    end else if (!bif.cpu_req && $urandom_range(0, 2) == 0) begin
      newCpuReq();
    end
    if (bif.dma_ack) begin
      if (bif.dma_req && $urandom_range(0, 1) == 1) newDmaReq();
      else bif.dma_req = 1'b0;
    end else if (!bif.dma_req && $urandom_range(0, 2) == 0) begin
      newDmaReq();
    end
  endtask

  initial begin
    int n;
    int budget;
    bit prev_cs;
    bit seen;
    bit cen_now;
    int n_en;

    bif.cpu_req = 0; bif.cpu_addr = 0; bif.cpu_din = 0; bif.cpu_we = 0;
    bif.dma_req = 0; bif.dma_addr = 0; bif.dma_din = 0; bif.dma_we = 0;
    bif.bus_dout = 0; bif.bus_wait = 0;

    // Reset state
    repeat (3) tick();
    checkOutput("reset_cs", 32'(bif.bus_cs), 0);
    checkOutput("reset_we", 32'(bif.bus_we), 0);
    checkOutput("reset_addr", 32'(bif.bus_addr), 0);
    checkOutput("reset_din", 32'(bif.bus_din), 0);
    checkOutput("reset_rdata", 32'(bif.rdata), 0);
    checkOutput("reset_acks", 32'({bif.cpu_ack, bif.dma_ack}), 0);
    checkOutput("reset_gnt", 32'(bif.dma_gnt), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // DMA write 0x1234 to 0x000201, upper byte only
    bif.dma_req = 1; bif.dma_addr = 24'h000201; bif.dma_din = 16'h1234; bif.dma_we = 2'b10;
    bif.bus_dout = 16'h0F0F;
    tick();
    checkOutput("dmaw_addr", 32'(bif.bus_addr), 32'h000201);
    checkOutput("dmaw_din", 32'(bif.bus_din), 32'h1234);
    checkOutput("dmaw_we_n0", 32'(bif.bus_we), 32'h2);
    checkOutput("dmaw_gnt", 32'(bif.dma_gnt), 1);
    tick();
    checkOutput("dmaw_we_n1", 32'({bif.bus_cs, bif.bus_we}), 32'h6);
    tick();
    checkOutput("dmaw_we_n2", 32'({bif.bus_cs, bif.bus_we, bif.dma_ack}), 32'hC);
    tick();
    checkOutput("dmaw_ack_n3", 32'({bif.dma_ack, bif.cpu_ack, bif.bus_cs, bif.bus_we}), 32'h10);
    bif.dma_req = 0;
    tick();
    checkOutput("dmaw_ack_end", 32'(bif.dma_ack), 0);

    // CPU read of 0x000100 returning 0xA55A
    bif.cpu_req = 1; bif.cpu_addr = 24'h000100; bif.cpu_we = 2'b00; bif.cpu_din = 16'h7777;
    bif.bus_dout = 16'hA55A;
    tick();
    checkOutput("cpur_grant", 32'({bif.bus_cs, bif.dma_gnt, bif.bus_we}), 32'h8);
    checkOutput("cpur_addr", 32'(bif.bus_addr), 32'h000100);
    tick();
    tick();
    checkOutput("cpur_noack_yet", 32'(bif.cpu_ack), 0);
    tick();
    checkOutput("cpur_ack", 32'({bif.cpu_ack, bif.dma_ack, bif.bus_cs}), 32'h4);
    checkOutput("cpur_rdata", 32'(bif.rdata), 32'hA55A);
    bif.cpu_req = 0;
    bif.bus_dout = 16'h1111;
    tick();
    tick();
    checkOutput("cpur_rdata_held", 32'(bif.rdata), 32'hA55A);

    // Both requesters held continuously: DMA x4 then CPU, repeating
    bif.cpu_req = 1; bif.cpu_addr = 24'h00C000; bif.cpu_we = 2'b00;
    bif.dma_req = 1; bif.dma_addr = 24'h00D000; bif.dma_we = 2'b01; bif.dma_din = 16'h5A5A;
    prev_cs = bif.bus_cs;
    n = 0;
    budget = 0;
    while (n < 10 && budget < 200) begin
      tick();
      budget++;
      if (bif.bus_cs && !prev_cs) begin
        checkOutput($sformatf("grant_order[%0d]", n), 32'(bif.dma_gnt), (n % 5 == 4) ? 0 : 1);
        n++;
      end
      prev_cs = bif.bus_cs;
    end
    if (n < 10) checkOutput("grant_order_timeout", n, 10);
    bif.cpu_req = 0; bif.dma_req = 0;
    repeat (8) tick();

    // Reset in the middle of a CPU write aborts it with no ack
    bif.cpu_req = 1; bif.cpu_addr = 24'h00ABCD; bif.cpu_din = 16'hBEEF; bif.cpu_we = 2'b11;
    tick();
    checkOutput("rstw_cs_we", 32'({bif.bus_cs, bif.bus_we}), 32'h7);
    tick();
    rst = 1'b1;
    bif.cpu_req = 0;
    #1;
    checkOutput("rstw_abort", 32'({bif.bus_cs, bif.bus_we, bif.cpu_ack}), 0);
    checkOutput("rstw_addr", 32'(bif.bus_addr), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rstw_no_ack", 32'(bif.cpu_ack), 0);
    end
    bif.cpu_req = 1;
    n = 0;
    while (!bif.cpu_ack && n < 20) begin
      tick();
      n++;
    end
    checkOutput("rstw_reissue_latency", n, 4);
    bif.cpu_req = 0;
    repeat (2) tick();

    // cen alternating: only enabled edges count, ack held while cen=0
    bif.dma_req = 1; bif.dma_addr = 24'h000400; bif.dma_we = 2'b00;
    seen = 0;
    n_en = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cen = (i % 2 == 0);
      cen_now = cen;
      tick();
      if (cen_now) n_en++;
      if (bif.dma_ack) seen = 1;
    end
    checkOutput("cen_ack_edges", seen ? n_en : 0, 4);
    bif.dma_req = 0;
    cen = 0;
    tick();
    checkOutput("cen_ack_hold", 32'(bif.dma_ack), 1);
    cen = 1;
    tick();
    checkOutput("cen_ack_release", 32'(bif.dma_ack), 0);
    tick();

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        bif.cpu_req = 0;
        bif.dma_req = 0;
        tick();
        rst = 1'b0;
      end
      applyStimulus();
      tick();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
